// File: rtl/key_cmd_pkg.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// key_cmd_pkg
// Shared constants for the key command block:
//   - command codes presented on cmd_code
//   - FSM state encoding used by key_cmd
//   - button bit positions and the default debounce depth
//   - dir_code(): maps a one-hot direction event vector to its command code
// -----------------------------------------------------------------------------
package key_cmd_pkg;

  // Default number of agreeing sample ticks needed to flip a debounced button.
  // Legal range is 2..15; the debounce counter is 4 bits wide.
  localparam int unsigned DB_SAMPLES_DEFAULT = 4;

  // Number of buttons handled by the block.
  localparam int NUM_BTN = 5;

  // Button bit positions inside btn_raw / btn_stable.
  localparam int BTN_UP      = 0;
  localparam int BTN_DOWN    = 1;
  localparam int BTN_LEFT    = 2;
  localparam int BTN_RIGHT   = 3;
  localparam int BTN_RESTART = 4;

  // Command codes.
  localparam logic [2:0] CMD_NONE    = 3'd0;
  localparam logic [2:0] CMD_UP      = 3'd1;
  localparam logic [2:0] CMD_DOWN    = 3'd2;
  localparam logic [2:0] CMD_LEFT    = 3'd3;
  localparam logic [2:0] CMD_RIGHT   = 3'd4;
  localparam logic [2:0] CMD_RESTART = 3'd5;

  // FSM state encoding.
  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_PENDING      = 2'd1;
  localparam logic [1:0] ST_WAIT_RELEASE = 2'd2;

  // Direction event vector (bits [3:0] of the press-event vector) to command
  // code. Anything other than exactly one direction bit maps to CMD_NONE.
  function automatic logic [2:0] dir_code(input logic [3:0] i_ev);
    logic [2:0] v_code;
    case (i_ev)
      4'b0001: v_code = CMD_UP;
      4'b0010: v_code = CMD_DOWN;
      4'b0100: v_code = CMD_LEFT;
      4'b1000: v_code = CMD_RIGHT;
      default: v_code = CMD_NONE;
    endcase
    return v_code;
  endfunction

endpackage

// File: rtl/key_cmd_debounce.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// key_debounce
// One button: 2-flop synchronizer into clk, agreement counter and debounced
// level. The counter only moves on i_tick (the slow sample strobe):
//   - synced sample differs from the stable level -> count up
//   - synced sample equals the stable level       -> count cleared
//   - count reaches DB_SAMPLES                     -> stable level flips,
//                                                     count cleared
// Between ticks everything except the synchronizer is frozen, so a stuck
// sample clock freezes the debounced level.
//
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   i_tick    in   one-cycle sample strobe
//   i_raw     in   raw (asynchronous) button level, active high
//   o_stable  out  debounced button level (registered)
// -----------------------------------------------------------------------------
module key_debounce
  import key_cmd_pkg::*;
#(
  parameter int unsigned DB_SAMPLES = DB_SAMPLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_tick,
  input  logic i_raw,
  output logic o_stable
);

  localparam logic [3:0] CNT_LAST = 4'(DB_SAMPLES);

  logic       r_meta;
  logic       r_sync;
  logic       r_stable;
  logic [3:0] r_cnt;

  logic       w_differs;
  logic [3:0] w_cnt_next;

  assign w_differs  = r_sync ^ r_stable;
  assign w_cnt_next = r_cnt + 4'd1;
  assign o_stable   = r_stable;

  // Two-flop synchronizer for the raw button level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
    end
  end

  // Agreement counter and debounced level, advanced only on sample ticks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= 4'd0;
      r_stable <= 1'b0;
    end else if (i_tick) begin
      if (!w_differs) begin
        r_cnt <= 4'd0;
      end else if (w_cnt_next == CNT_LAST) begin
        r_cnt    <= 4'd0;
        r_stable <= ~r_stable;
      end else begin
        r_cnt <= w_cnt_next;
      end
    end else begin
      r_cnt    <= r_cnt;
      r_stable <= r_stable;
    end
  end

endmodule

// File: rtl/key_cmd.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// key_cmd
// Turns five raw push buttons into single game commands.
//   - slow_in (a divided clock, treated as data) is synchronized and
//     edge-detected into a one-cycle sample tick.
//   - Each button is debounced by its own key_debounce instance.
//   - A 0->1 change of a debounced bit is a press event; events are looked
//     at in the cycle after the tick that produced them.
//   - The FSM issues one command per press and then waits for all buttons
//     to be released before accepting another press. Presses arriving while
//     a command is pending or while waiting for release are dropped.
//
// Ports
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   slow_in     in   sample clock from the divider (rising edge = one tick)
//   btn_raw     in   [0] up [1] down [2] left [3] right [4] restart
//   cmd_ready   in   consumer accepts the pending command
//   cmd_valid   out  command pending (registered)
//   cmd_code    out  command code, 0 whenever cmd_valid is 0 (registered)
//   btn_stable  out  debounced button levels (registered)
// -----------------------------------------------------------------------------
module key_cmd
  import key_cmd_pkg::*;
#(
  parameter int unsigned DB_SAMPLES = DB_SAMPLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       slow_in,
  input  logic [4:0] btn_raw,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic [4:0] btn_stable
);

  logic       r_slow_meta;
  logic       r_slow_sync;
  logic       r_slow_prev;
  logic       w_tick;

  logic [4:0] w_stable;
  logic [4:0] r_stable_prev;
  logic [4:0] w_press;
  logic [2:0] w_dir;

  logic [1:0] r_state;
  logic       r_cmd_valid;
  logic [2:0] r_cmd_code;
  logic [1:0] w_state_next;
  logic       w_valid_next;
  logic [2:0] w_code_next;

  // Synchronize slow_in and keep its previous synced sample for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slow_meta <= 1'b0;
      r_slow_sync <= 1'b0;
      r_slow_prev <= 1'b0;
    end else begin
      r_slow_meta <= slow_in;
      r_slow_sync <= r_slow_meta;
      r_slow_prev <= r_slow_sync;
    end
  end

  assign w_tick = r_slow_sync & ~r_slow_prev;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    key_debounce #(
      .DB_SAMPLES (DB_SAMPLES)
    ) u_debounce (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_tick   (w_tick),
      .i_raw    (btn_raw[gi]),
      .o_stable (w_stable[gi])
    );
  end

  // Delayed copy of the debounced levels; a press shows up for exactly the
  // one cycle after the tick that raised the debounced bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stable_prev <= 5'd0;
    end else begin
      r_stable_prev <= w_stable;
    end
  end

  assign w_press = w_stable & ~r_stable_prev;
  assign w_dir   = dir_code(w_press[3:0]);

  // Next-state / next-output decode for the command FSM.
  always_comb begin
    w_state_next = r_state;
    w_valid_next = r_cmd_valid;
    w_code_next  = r_cmd_code;
    case (r_state)
      ST_IDLE: begin
        if (w_press[BTN_RESTART]) begin
          // Restart wins over any simultaneous direction presses.
          w_state_next = ST_PENDING;
          w_valid_next = 1'b1;
          w_code_next  = CMD_RESTART;
        end else if (w_press != 5'd0) begin
          // A direction command needs a lone direction press with nothing
          // else held; any other combination is swallowed until release.
          if ((w_dir != CMD_NONE) && (w_stable == w_press)) begin
            w_state_next = ST_PENDING;
            w_valid_next = 1'b1;
            w_code_next  = w_dir;
          end else begin
            w_state_next = ST_WAIT_RELEASE;
            w_valid_next = 1'b0;
            w_code_next  = CMD_NONE;
          end
        end else begin
          w_state_next = ST_IDLE;
          w_valid_next = 1'b0;
          w_code_next  = CMD_NONE;
        end
      end
      ST_PENDING: begin
        if (cmd_ready) begin
          w_state_next = ST_WAIT_RELEASE;
          w_valid_next = 1'b0;
          w_code_next  = CMD_NONE;
        end else begin
          w_state_next = ST_PENDING;
          w_valid_next = 1'b1;
          w_code_next  = r_cmd_code;
        end
      end
      ST_WAIT_RELEASE: begin
        if (w_stable == 5'd0) begin
          w_state_next = ST_IDLE;
        end else begin
          w_state_next = ST_WAIT_RELEASE;
        end
        w_valid_next = 1'b0;
        w_code_next  = CMD_NONE;
      end
      default: begin
        w_state_next = ST_IDLE;
        w_valid_next = 1'b0;
        w_code_next  = CMD_NONE;
      end
    endcase
  end

  // FSM state and registered command outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cmd_valid <= 1'b0;
      r_cmd_code  <= CMD_NONE;
    end else begin
      r_state     <= w_state_next;
      r_cmd_valid <= w_valid_next;
      r_cmd_code  <= w_code_next;
    end
  end

  assign cmd_valid  = r_cmd_valid;
  assign cmd_code   = r_cmd_code;
  assign btn_stable = w_stable;

endmodule

// File: tb/tb_key_cmd.sv
`timescale 1ns/1ps
// Self-checking bench for key_cmd (DB_SAMPLES = 4, clk 20 ns, slow_in 200 ns).
// Stimulus pushes the expected command codes into exp_q; the monitor pops one
// each time cmd_valid rises and checks the code, the latency from the
// debounced edge, code==0 while idle, and the drop after a handshake.
module tb_key_cmd;
  import key_cmd_pkg::*;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       slow_in   = 1'b0;
  logic       slow_en   = 1'b1;
  logic       cmd_ready = 1'b1;
  logic [4:0] btn_raw   = 5'd0;
  logic       cmd_valid;
  logic [2:0] cmd_code;
  logic [4:0] btn_stable;

  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] exp_q[$];

  key_cmd #(.DB_SAMPLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .slow_in    (slow_in),
    .btn_raw    (btn_raw),
    .cmd_ready  (cmd_ready),
    .cmd_valid  (cmd_valid),
    .cmd_code   (cmd_code),
    .btn_stable (btn_stable)
  );

  initial forever #10 clk = ~clk;

  // slow_in toggles on a 100 ns grid; holding slow_en low freezes its level.
  initial forever begin
    #100;
    if (slow_en) slow_in = ~slow_in;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Change buttons 55 ns after a slow_in rise (after that tick has sampled).
  task automatic press_at_tick(input logic [4:0] v);
    @(posedge slow_in);
    #55;
    btn_raw = v;
  endtask

  // Wait n slow_in rises, then past the tick update of btn_stable.
  task automatic wait_ticks(input int n);
    repeat (n) @(posedge slow_in);
    #65;
  endtask

  task automatic wait_valid(input string name);
    int k = 0;
    while (!cmd_valid && k < 400) begin
      @(negedge clk);
      k++;
    end
    chk(name, cmd_valid, 1'b1);
  endtask

  task automatic ready_pulse();
    @(posedge clk);
    #5 cmd_ready = 1'b1;
    @(posedge clk);
    #5 cmd_ready = 1'b0;
  endtask

  // Monitor / scoreboard.
  initial begin
    logic       prev_valid = 1'b0;
    logic       hs         = 1'b0;
    logic [4:0] stab_d1    = 5'd0;
    logic [4:0] stab_d2    = 5'd0;
    logic [2:0] cur_exp    = CMD_NONE;
    forever begin
      @(negedge clk);
      if (hs) chk("valid_drop_after_ready", cmd_valid, 1'b0);
      if (cmd_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_cmd: got code %0d with no command expected", cmd_code);
          cur_exp = CMD_NONE;
        end else begin
          cur_exp = exp_q.pop_front();
        end
        chk("latency_after_debounce", (stab_d1 != stab_d2), 1'b1);
      end
      if (cmd_valid) chk("cmd_code", cmd_code, cur_exp);
      else           chk("code_zero_when_idle", cmd_code, CMD_NONE);
      hs         = cmd_valid && cmd_ready;
      prev_valid = cmd_valid;
      stab_d2    = stab_d1;
      stab_d1    = btn_stable;
    end
  end

  initial begin
    #45;
    chk("rst_valid", cmd_valid, 1'b0);
    chk("rst_code", cmd_code, CMD_NONE);
    chk("rst_stable", btn_stable, 5'd0);
    rst_n = 1'b1;

    // Single up press held 10 ticks, consumer always ready.
    exp_q.push_back(CMD_UP);
    press_at_tick(5'b00001);
    wait_ticks(3);
    chk("s1_stable_before_4th", btn_stable, 5'b00000);
    wait_ticks(1);
    chk("s1_stable_on_4th", btn_stable, 5'b00001);
    wait_valid("s1_valid");
    repeat (2) @(negedge clk);
    chk("s1_valid_one_cycle", cmd_valid, 1'b0);
    wait_ticks(6);
    btn_raw = 5'd0;
    wait_ticks(5);
    chk("s1_released", btn_stable, 5'd0);

    // Bouncing left for 3 ticks, then steady.
    exp_q.push_back(CMD_LEFT);
    @(posedge slow_in);
    #55;
    for (int i = 0; i < 10; i++) begin
      btn_raw[2] = ~btn_raw[2];
      #60;
    end
    chk("s2_no_change_bounce", btn_stable, 5'd0);
    btn_raw = 5'b00100;
    wait_ticks(3);
    chk("s2_no_change_3_steady", btn_stable, 5'd0);
    wait_ticks(1);
    chk("s2_stable_4_steady", btn_stable, 5'b00100);
    wait_valid("s2_valid");
    btn_raw = 5'd0;
    wait_ticks(5);
    chk("s2_released", btn_stable, 5'd0);

    // Restart together with directions, then a two-direction chord.
    exp_q.push_back(CMD_RESTART);
    press_at_tick(5'b10011);
    wait_ticks(4);
    chk("s3_chord_stable", btn_stable, 5'b10011);
    wait_valid("s3_restart_valid");
    btn_raw = 5'd0;
    wait_ticks(5);
    chk("s3_released", btn_stable, 5'd0);
    press_at_tick(5'b00011);
    wait_ticks(4);
    repeat (3) @(negedge clk);
    chk("s3_two_dir_state", dut.r_state, ST_WAIT_RELEASE);
    chk("s3_two_dir_no_valid", cmd_valid, 1'b0);
    btn_raw = 5'b00001;
    wait_ticks(5);
    chk("s3_partial_stable", btn_stable, 5'b00001);
    chk("s3_partial_state", dut.r_state, ST_WAIT_RELEASE);
    btn_raw = 5'd0;
    wait_ticks(5);
    chk("s3_all_released", btn_stable, 5'd0);
    chk("s3_back_idle", dut.r_state, ST_IDLE);

    // Right with consumer stalled 50 cycles; up pressed meanwhile is dropped.
    cmd_ready = 1'b0;
    exp_q.push_back(CMD_RIGHT);
    press_at_tick(5'b01000);
    wait_ticks(4);
    wait_valid("s4_valid");
    press_at_tick(5'b01001);
    repeat (50) @(negedge clk);
    chk("s4_valid_held", cmd_valid, 1'b1);
    chk("s4_code_held", cmd_code, CMD_RIGHT);
    chk("s4_up_debounced", btn_stable, 5'b01001);
    ready_pulse();
    repeat (2) @(negedge clk);
    chk("s4_valid_fell", cmd_valid, 1'b0);
    cmd_ready = 1'b1;
    btn_raw   = 5'd0;
    wait_ticks(5);
    chk("s4_released", btn_stable, 5'd0);

    // slow_in stuck: debounced levels freeze, pending command still completes.
    cmd_ready = 1'b0;
    exp_q.push_back(CMD_DOWN);
    press_at_tick(5'b00010);
    wait_ticks(4);
    wait_valid("s5_valid");
    slow_en = 1'b0;
    btn_raw = 5'd0;
    repeat (60) @(negedge clk);
    chk("s5_stable_frozen", btn_stable, 5'b00010);
    chk("s5_valid_held", cmd_valid, 1'b1);
    ready_pulse();
    repeat (2) @(negedge clk);
    chk("s5_valid_fell", cmd_valid, 1'b0);
    chk("s5_stable_still_frozen", btn_stable, 5'b00010);
    cmd_ready = 1'b1;
    slow_en   = 1'b1;
    wait_ticks(5);
    chk("s5_released", btn_stable, 5'd0);

    // Reset while a command is pending; held button re-debounces.
    cmd_ready = 1'b0;
    exp_q.push_back(CMD_LEFT);
    press_at_tick(5'b00100);
    wait_ticks(4);
    wait_valid("s6_valid");
    @(negedge slow_in);
    @(negedge clk);
    #5 rst_n = 1'b0;
    #1;
    chk("s6_rst_valid", cmd_valid, 1'b0);
    chk("s6_rst_code", cmd_code, CMD_NONE);
    chk("s6_rst_stable", btn_stable, 5'd0);
    #29 rst_n = 1'b1;
    exp_q.push_back(CMD_LEFT);
    cmd_ready = 1'b1;
    wait_ticks(3);
    chk("s6_no_early_stable", btn_stable, 5'd0);
    chk("s6_no_early_valid", cmd_valid, 1'b0);
    wait_ticks(1);
    chk("s6_stable_again", btn_stable, 5'b00100);
    wait_valid("s6_valid_again");
    btn_raw = 5'd0;
    wait_ticks(5);
    chk("s6_released", btn_stable, 5'd0);

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
